// File: rtl/cpu_pkg.sv
// Shared definitions for the datapath and its controller: widths, ALU modes, IR fields.
// The optional DATAPATH_FLAGS_EN build adds the registered zero/carry flags in cpu_datapath.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int OPC_W  = 4;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] PC_STEP = 12'h001;
  localparam logic [ADDR_W-1:0] PC_ZERO = 12'h000;
  localparam logic [DATA_W-1:0] DATA_ZERO = 16'h0000;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_mode_e;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [DATA_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] ir_addr(input logic [DATA_W-1:0] ir);
    return ir[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational add/subtract unit; carry is carry-out on add and borrow (a < b) on subtract.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_mode_e         i_mode,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // One extra bit holds the carry-out of the add and the borrow of the subtract.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Select the operation result and its status bit.
  always_comb begin
    o_result = w_sum[DATA_W-1:0];
    o_carry  = w_sum[DATA_W];
    case (i_mode)
      ALU_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      ALU_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      default: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator-style datapath: A, B, C, IR and PC registers around a shared add/sub ALU.
// Define DATAPATH_FLAGS_EN to register zero/carry on each loadC; otherwise both read 0.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              loadA,
  input  logic              loadB,
  input  logic              loadC,
  input  logic              loadIR,
  input  logic              loadPC,
  input  logic              incPC,
  input  logic              mode,
  input  logic              selA,
  input  logic              selB,
  input  logic              we_DM,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              dm_we,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_c;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_pc;

  logic [DATA_W-1:0] w_a_src;
  logic [DATA_W-1:0] w_b_src;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;

  assign w_a_src = selA ? r_c : dm_rdata;
  assign w_b_src = selB ? r_c : dm_rdata;

  cpu_alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_mode   (alu_mode_e'(mode)),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  // Operand and result registers; A/B sample the pre-edge C, so loadA with loadC reads the old C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= DATA_ZERO;
      r_b <= DATA_ZERO;
      r_c <= DATA_ZERO;
    end else if (en) begin
      if (loadA) r_a <= w_a_src;
      if (loadB) r_b <= w_b_src;
      if (loadC) r_c <= w_alu_result;
    end
  end

  // Instruction register and program counter; a jump (loadPC) overrides increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= DATA_ZERO;
      r_pc <= PC_ZERO;
    end else if (en) begin
      if (loadIR) r_ir <= im_data;
      if (loadPC) begin
        r_pc <= ir_addr(r_ir);
      end else if (incPC) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

`ifdef DATAPATH_FLAGS_EN
  logic r_zero;
  logic r_carry;

  // Status flags track the most recent ALU result written into C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (en && loadC) begin
      r_zero  <= (w_alu_result == DATA_ZERO);
      r_carry <= w_alu_carry;
    end
  end

  assign zero  = r_zero;
  assign carry = r_carry;
`else
  logic w_flags_unused;
  assign w_flags_unused = w_alu_carry;
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif

  assign opcode   = ir_opcode(r_ir);
  assign im_addr  = r_pc;
  assign dm_addr  = ir_addr(r_ir);
  assign dm_wdata = r_a;
  assign dm_we    = we_DM & en;

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: en  in  1  global enable; when 0, no register updates occur.
REQ-004 SHALL have ports: loadA, loadB, loadC, loadIR, loadPC, incPC  in  1 each  register strobes from controller.
REQ-005 SHALL have ports: mode  in  1  ALU op (0 = A+B, 1 = A-B).
REQ-006 SHALL have ports: selA, selB  in  1 each  source select for A/B (0 = dm_rdata, 1 = C).
REQ-007 SHALL have ports: we_DM  in  1  data-memory write request.
REQ-008 SHALL have ports: opcode  out  4  IR[15:12], fed back to controller.
REQ-009 SHALL have ports: im_addr  out  12  instruction address (= PC); im_data  in  16  instruction word, combinational read.
REQ-010 SHALL have ports: dm_addr  out  12  (= IR[11:0]); dm_wdata  out  16  (= A); dm_rdata  in  16; dm_we  out  1.
REQ-011 SHALL have ports: zero, carry  out  1 each  ALU status flags.

Function
REQ-012 Registers A, B, C, IR shall be 16-bit and PC 12-bit, each updated only when en=1 and its strobe is 1.
REQ-013 loadIR shall capture im_data in IR; opcode follows IR with zero added latency after the edge.
REQ-014 loadA shall capture (selA ? C : dm_rdata); loadB shall capture (selB ? C : dm_rdata).
REQ-015 loadC shall capture the ALU result (A+B or A-B per mode), truncated modulo 2^16.
REQ-016 PC update precedence shall be: loadPC (PC <= IR[11:0]) over incPC (PC <= PC+1); with both asserted, loadPC wins.
REQ-017 PC increment shall wrap 0xFFF -> 0x000 with no flag.
REQ-018 Simultaneous loadA and loadC shall take the pre-edge value of C for A (read-before-write).
REQ-019 dm_we shall equal we_DM & en combinationally; dm_addr and dm_wdata shall be combinational from IR and A.
REQ-020 With en=0, all registers shall hold and dm_we shall be 0, regardless of strobes.

Reset
REQ-021 On rst=1 at a rising edge, A, B, C, IR, PC and the flags shall clear to 0; opcode, im_addr and dm_addr shall then read 0.
REQ-022 rst shall take priority over en and all strobes, including mid-instruction; there shall be no partial update on the reset edge.

Configuration
REQ-023 With macro DATAPATH_FLAGS_EN defined, zero and carry shall be registered on every loadC edge: zero = (result == 0); carry = carry-out for add and borrow (A < B unsigned) for sub.
REQ-024 Without DATAPATH_FLAGS_EN, zero and carry shall be tied to 0 and no flag registers shall be synthesized.

Structure
REQ-025 Shared package cpu_pkg shall hold DATA_W=16, ADDR_W=12, OPC_W=4, the ALU mode encodings and the opcode-field bit positions; the controller shall use the same package.
REQ-026 The ALU shall be a separate combinational sub-module cpu_alu (a, b, mode -> result, carry); all state shall remain in cpu_datapath.

Verification
REQ-027 rst=1 for one edge with all strobes high -> all registers, opcode, im_addr and flags read 0 on the next cycle.
REQ-028 im_data=0x1005, loadIR -> opcode=0x1 and dm_addr=0x005; then dm_rdata=0x0003 with loadA (selA=0), dm_rdata=0x0004 with loadB (selB=0), then loadC (mode=0) -> C=0x0007.
REQ-029 A=0x0002, B=0x0005, mode=1, loadC -> C=0xFFFD; with DATAPATH_FLAGS_EN: carry=1, zero=0.
REQ-030 A=0xFFFF, B=0x0001, mode=0, loadC -> C=0x0000; with the macro: zero=1, carry=1; without it: both 0.
REQ-031 PC=0xFFF with incPC -> PC=0x000; IR=0x3ABC with loadPC and incPC both high -> PC=0xABC.
REQ-032 en=0 with all strobes and we_DM high -> no register change and dm_we=0; en=1 with we_DM=1 -> dm_we=1, dm_wdata=A.
